stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Run/pause/lap/clear controller for a cascaded BCD digit-counter chain (NUM_DIGITS decade counters, carries chained).
- Contains a tick prescaler and drives the chain's common ENABLE and RESET.
- Reads the chain's digits and final carry-out; presents either live or frozen (lap) digits to the display driver.
- Button inputs are already synchronised/debounced levels; this block does its own rising-edge detection.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the chain; bus width 4*NUM_DIGITS.
- TICK_DIV, 100000, CLK cycles per count tick; legal range ≥2.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset; clock CLK.
- START_STOP  in  1  level, debounced; a rising edge toggles run/pause.
- LAP  in  1  level; a rising edge freezes or unfreezes the display while running.
- CLEAR  in  1  level; a rising edge zeroes the chain when stopped.
- DIGITS  in  4*NUM_DIGITS  live BCD digits from the chain, digit 0 in LSBs.
- OVF  in  1  registered carry-out of the last digit counter, 1-cycle pulse.
- CNT_ENABLE  out  1  tick strobe to the chain.
- CNT_RESET  out  1  1-cycle clear pulse to the chain.
- DISPLAY  out  4*NUM_DIGITS  digits to the display.
- STATE  out  3  state encoding: IDLE=0, RUN=1, LAP=2, PAUSE=3, HALT=4.
- RUNNING  out  1  high in RUN or LAP.

Behaviour:
- Edge detect:
  - Registers prev_start, prev_lap and prev_clear.
  - Each edge signal = level & ~prev (combinational).
  - All prev registers reset to 1, so a button held through reset produces no event.
- Event priority in the same cycle: OVF > start > lap > clear. Only the highest-priority applicable event acts; the others are dropped.
- State transitions are registered at the edge where the event is sampled, so STATE changes one cycle after the input is first sampled high.
  - IDLE: start → RUN. clear → IDLE with CNT_RESET pulse. Lap ignored. OVF ignored.
  - RUN: OVF → HALT. start → PAUSE. lap → LAP and latch DIGITS into lap_reg on the same edge. clear ignored.
  - LAP: OVF → HALT. start → PAUSE (display returns to live). lap → RUN. clear ignored.
  - PAUSE: start → RUN. clear → IDLE with CNT_RESET pulse. Lap ignored. OVF ignored (no ticks can occur).
  - HALT: clear → IDLE with CNT_RESET pulse. All other events ignored.
- Prescaler:
  - Counter width clog2(TICK_DIV).
  - Increments only in RUN/LAP; wraps from TICK_DIV-1 to 0.
  - Holds its value in PAUSE, so a partial tick period is preserved across pause.
  - Zeroed by RESET and by any accepted clear.
- CNT_ENABLE:
  - Registered; high for exactly 1 cycle in the cycle after the prescaler reaches TICK_DIV-1 while in RUN/LAP.
  - Period is exactly TICK_DIV cycles during continuous running.
  - Forced 0 in IDLE, PAUSE and HALT, including the first cycle after leaving RUN/LAP.
- CNT_RESET: registered; high for 1 cycle in the cycle after a clear is accepted. It is never asserted in the same cycle as CNT_ENABLE.
- DISPLAY (combinational from state/regs):
  - RUN, IDLE, PAUSE: DIGITS.
  - LAP: lap_reg.
  - HALT: all digits 4'h9 (saturated indication; the chain has already wrapped to 0).
- Reset values:
  - STATE=IDLE.
  - CNT_ENABLE=0, CNT_RESET=0, RUNNING=0.
  - lap_reg=0 and prescaler=0.
  - DISPLAY=DIGITS.
- RESET mid-operation: returns to IDLE immediately, with no CNT_RESET pulse. The chain shares RESET.
- lap_reg holds its value after leaving LAP; it is only overwritten by the next lap entry.

Test Plan:
1. TICK_DIV=4. RESET 2 cycles, then START_STOP rising → STATE=1 next cycle. CNT_ENABLE pulses every 4 cycles, first pulse 4 cycles after entering RUN. No CNT_RESET.
2. Running with DIGITS=16'h0123. LAP rising → STATE=2, DISPLAY holds 16'h0123 while DIGITS advances to 16'h0125. LAP again → STATE=1, DISPLAY tracks DIGITS.
3. Pause after prescaler=2. Wait 10 cycles → no CNT_ENABLE. Resume → first CNT_ENABLE 2 cycles after re-entering RUN. CLEAR pressed in RUN → ignored. CLEAR in PAUSE → CNT_RESET one cycle, STATE=0, prescaler=0.
4. OVF and START_STOP rising in the same cycle in RUN → STATE=4 (not PAUSE). DISPLAY=16'h9999, CNT_ENABLE=0. START_STOP ignored. CLEAR → STATE=0 plus CNT_RESET pulse.
5. START_STOP held high through RESET release → no transition. Release then press → RUN. RESET asserted mid-LAP → STATE=0, CNT_ENABLE=0, CNT_RESET=0, lap_reg=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a cascaded BCD counter chain.
// Owns the tick prescaler and chooses between live, frozen-lap or saturated display digits.
module stopwatch_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START_STOP,
    input  logic                    LAP,
    input  logic                    CLEAR,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic                    OVF,
    output logic                    CNT_ENABLE,
    output logic                    CNT_RESET,
    output logic [4*NUM_DIGITS-1:0] DISPLAY,
    output logic [2:0]              STATE,
    output logic                    RUNNING
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_PAUSE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_prev_start;
    logic                    r_prev_lap;
    logic                    r_prev_clear;
    logic [PW-1:0]           r_presc;
    logic [4*NUM_DIGITS-1:0] r_lap;
    logic                    r_cnt_enable;
    logic                    r_cnt_reset;

    logic   w_start_edge;
    logic   w_lap_edge;
    logic   w_clear_edge;
    state_t w_next;
    logic   w_clear_acc;
    logic   w_lap_latch;
    logic   w_tick_en;

    assign w_start_edge = START_STOP & ~r_prev_start;
    assign w_lap_edge   = LAP        & ~r_prev_lap;
    assign w_clear_edge = CLEAR      & ~r_prev_clear;

    // Each state only looks at the events it honours, in priority order OVF > start > lap > clear.
    always_comb begin
        w_next      = r_state;
        w_clear_acc = 1'b0;
        w_lap_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge)      w_next = S_RUN;
                else if (w_clear_edge) w_clear_acc = 1'b1;
            end
            S_RUN: begin
                if (OVF)               w_next = S_HALT;
                else if (w_start_edge) w_next = S_PAUSE;
                else if (w_lap_edge) begin
                    w_next      = S_LAP;
                    w_lap_latch = 1'b1;
                end
            end
            S_LAP: begin
                if (OVF)               w_next = S_HALT;
                else if (w_start_edge) w_next = S_PAUSE;
                else if (w_lap_edge)   w_next = S_RUN;
            end
            S_PAUSE: begin
                if (w_start_edge) w_next = S_RUN;
                else if (w_clear_edge) begin
                    w_next      = S_IDLE;
                    w_clear_acc = 1'b1;
                end
            end
            S_HALT: begin
                if (w_clear_edge) begin
                    w_next      = S_IDLE;
                    w_clear_acc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The prescaler only advances on cycles that stay inside RUN/LAP, so leaving keeps enable low.
    assign w_tick_en = ((r_state == S_RUN) || (r_state == S_LAP)) &&
                       ((w_next  == S_RUN) || (w_next  == S_LAP));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_prev_start <= 1'b1;
            r_prev_lap   <= 1'b1;
            r_prev_clear <= 1'b1;
            r_presc      <= '0;
            r_lap        <= '0;
            r_cnt_enable <= 1'b0;
            r_cnt_reset  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_prev_start <= START_STOP;
            r_prev_lap   <= LAP;
            r_prev_clear <= CLEAR;
            r_cnt_reset  <= w_clear_acc;
            r_cnt_enable <= w_tick_en && (r_presc == PRESC_LAST);
            if (w_clear_acc)
                r_presc <= '0;
            else if (w_tick_en)
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            if (w_lap_latch)
                r_lap <= DIGITS;
        end
    end

    always_comb begin
        case (r_state)
            S_LAP:   DISPLAY = r_lap;
            S_HALT:  DISPLAY = {NUM_DIGITS{4'h9}};
            default: DISPLAY = DIGITS;
        endcase
    end

    assign STATE      = r_state;
    assign RUNNING    = (r_state == S_RUN) || (r_state == S_LAP);
    assign CNT_ENABLE = r_cnt_enable;
    assign CNT_RESET  = r_cnt_reset;

endmodule
